nv_nvdla_cdma_rd_arb: RTL and testbench
=======================================

NV_NVDLA_CDMA_RD_ARB -- requirements
Module: nv_nvdla_cdma_rd_arb

Interface
REQ-001 Parameter TAG_DEPTH, default 8: response-routing tag FIFO depth; power of 2, >=2.
REQ-002 nvdla_core_clk  in  1  sole clock; all state on its rising edge.
REQ-003 nvdla_core_rst  in  1  reset; synchronous, active-high.
REQ-004 clt0_req_valid / clt1_req_valid  in  1 each  client read-request valid.
REQ-005 clt0_req_pd / clt1_req_pd  in  79 each  [63:0] addr, [78:64] size (atoms-1).
REQ-006 clt0_req_ready / clt1_req_ready  out  1 each  request accepted this cycle.
REQ-007 mc_req_valid  out  1;  mc_req_pd  out  79;  mc_req_ready  in  1  request to MC read port.
REQ-008 mc_rsp_valid  in  1;  mc_rsp_pd  in  514;  mc_rsp_ready  out  1  MC read response, one atom per beat.
REQ-009 clt0_rsp_valid / clt1_rsp_valid  out  1 each;  clt0_rsp_pd / clt1_rsp_pd  out  514 each;  clt0_rsp_ready / clt1_rsp_ready  in  1 each.
REQ-010 cfg_max_atoms  in  16  outstanding-atom credit limit; quasi-static.
REQ-011 arb_idle  out  1  no request held, no tags, zero outstanding atoms.
REQ-012 stall_cnt  out  32  credit/tag stall counter (see Configuration).

Function
REQ-013 Output slot SHALL be free when mc_req_valid=0 or mc_req_ready=1.
REQ-014 Client eligible iff valid, outs_cnt+size+1 <= cfg_max_atoms (17-bit compare, no overflow), tag count < TAG_DEPTH (count before any same-cycle pop).
REQ-015 Slot free and >=1 eligible: exactly one grant, round-robin; client not granted last wins ties; last-grant pointer resets to 1 (client0 wins first tie).
REQ-016 cltN_req_ready SHALL equal grant to N, combinational, same cycle; never asserted while slot busy.
REQ-017 Grant SHALL load mc_req_pd register with granted pd; mc_req_valid=1 next cycle (1-cycle latency); pd/valid held stable until mc_req_ready=1.
REQ-018 Slot free, no grant: mc_req_valid SHALL drop to 0 next cycle.
REQ-019 On grant: outs_cnt += size+1; tag {client, size+1} pushed to FIFO.
REQ-020 Each accepted response beat (mc_rsp_valid & mc_rsp_ready): outs_cnt -= 1; grant and beat in same cycle apply both (net change).
REQ-021 Head tag selects destination; head beat counter counts accepted beats; head popped on beat count == atoms; counter restarts at 0 for next tag.
REQ-022 mc_rsp_ready = 0 if FIFO empty, else destination's cltN_rsp_ready; cltN_rsp_valid = mc_rsp_valid & FIFO non-empty & head==N; mc_rsp_pd routed combinationally to both cltN_rsp_pd.
REQ-023 Response with FIFO empty SHALL be refused (ready 0), no state change.
REQ-024 cfg_max_atoms=0 SHALL block all grants; outstanding traffic still drains.
REQ-025 arb_idle = !mc_req_valid & FIFO empty & outs_cnt==0, registered-state derived.

Reset
REQ-026 Reset cycle: mc_req_valid 0, mc_req_pd 0, all req/rsp readies and rsp valids 0, outs_cnt 0, FIFO empty, beat counter 0, pointer 1, stall_cnt 0.
REQ-027 arb_idle SHALL read 1 first cycle after reset.
REQ-028 Reset mid-operation SHALL discard held request, tags and credits; MC reset by same reset (system requirement).

Configuration
REQ-029 Macro NVDLA_CDMA_RD_ARB_STALL_CNT_EN defined: stall_cnt +1 per cycle with slot free, >=1 client valid, none eligible; saturates at 32'hFFFF_FFFF.
REQ-030 Macro undefined: stall_cnt tied 32'h0, no counter register; all other behaviour identical.

Verification
REQ-031 cfg=64; both clients valid, size 3 each, mc_req_ready=1 -> grants clt0,clt1,clt0,clt1; outs_cnt 16 after 4 grants.
REQ-032 cfg=8; clt0 size 7 granted, clt1 size 0 valid -> clt1 blocked until 1 beat returns; grant next cycle; stall_cnt=stalled cycles (0 without macro).
REQ-033 TAG_DEPTH=8, cfg=1000, size 0, no responses -> 8 grants then clt*_req_ready=0; one beat frees 1 grant.
REQ-034 mc_req_ready=0 for 5 cycles after grant -> mc_req_valid=1, pd unchanged, no further grants; ready=1 -> next grant same cycle.
REQ-035 Tags clt1(2 atoms), clt0(1): 3 beats, clt1_rsp_ready=0 on beat 2 -> mc_rsp_ready=0 that cycle; beats 1-2 to clt1, beat 3 to clt0; arb_idle=1 after.
REQ-036 Reset asserted with 3 tags outstanding -> next cycle all counters 0, arb_idle=1, mc_rsp_ready=0.

Source files
------------

// File: rtl/nv_nvdla_cdma_rd_arb.sv
// Two-client read-request arbiter for the CDMA MC read port with credit/tag-based response routing.
// Optional stall counter is built only when NVDLA_CDMA_RD_ARB_STALL_CNT_EN is defined.
module nv_nvdla_cdma_rd_arb #(
    parameter int TAG_DEPTH = 8
) (
    input  logic         nvdla_core_clk,
    input  logic         nvdla_core_rst,
    input  logic         clt0_req_valid,
    input  logic [78:0]  clt0_req_pd,
    output logic         clt0_req_ready,
    input  logic         clt1_req_valid,
    input  logic [78:0]  clt1_req_pd,
    output logic         clt1_req_ready,
    output logic         mc_req_valid,
    output logic [78:0]  mc_req_pd,
    input  logic         mc_req_ready,
    input  logic         mc_rsp_valid,
    input  logic [513:0] mc_rsp_pd,
    output logic         mc_rsp_ready,
    output logic         clt0_rsp_valid,
    output logic [513:0] clt0_rsp_pd,
    input  logic         clt0_rsp_ready,
    output logic         clt1_rsp_valid,
    output logic [513:0] clt1_rsp_pd,
    input  logic         clt1_rsp_ready,
    input  logic [15:0]  cfg_max_atoms,
    output logic         arb_idle,
    output logic [31:0]  stall_cnt
);

    localparam int AW = (TAG_DEPTH > 1) ? $clog2(TAG_DEPTH) : 1;
    localparam logic [AW:0] TAG_FULL = (AW+1)'(TAG_DEPTH);
    localparam logic [AW:0] TAG_ONE  = (AW+1)'(1);

    // Every interface transfers on a cycle where valid and ready are both high;
    // valid never waits on ready, and a held mc request keeps pd stable until taken.
    logic [15:0]   outs_cnt;
    logic [15:0]   outs_nxt;
    logic [AW-1:0] wr_ptr;
    logic [AW-1:0] rd_ptr;
    logic [AW:0]   tag_cnt;
    logic [AW:0]   tag_cnt_nxt;
    logic [15:0]   beat_cnt;
    logic          last_gnt;
    logic [16:0]   tag_mem [TAG_DEPTH];

    logic          slot_free;
    logic          tag_space;
    logic [15:0]   need0;
    logic [15:0]   need1;
    logic [16:0]   sum0;
    logic [16:0]   sum1;
    logic          elig0;
    logic          elig1;
    logic          gnt0;
    logic          gnt1;
    logic          gnt_any;
    logic [78:0]   gnt_pd;
    logic [15:0]   gnt_atoms;
    logic          fifo_ne;
    logic          head_clt;
    logic [15:0]   head_atoms;
    logic          beat;
    logic          head_done;
    logic          pop;

    assign slot_free = !mc_req_valid || mc_req_ready;
    assign tag_space = tag_cnt < TAG_FULL;

    // Credit check is done in 17 bits so a large size can never wrap past the limit.
    assign need0 = {1'b0, clt0_req_pd[78:64]} + 16'd1;
    assign need1 = {1'b0, clt1_req_pd[78:64]} + 16'd1;
    assign sum0  = {1'b0, outs_cnt} + {1'b0, need0};
    assign sum1  = {1'b0, outs_cnt} + {1'b0, need1};
    assign elig0 = clt0_req_valid && (sum0 <= {1'b0, cfg_max_atoms}) && tag_space;
    assign elig1 = clt1_req_valid && (sum1 <= {1'b0, cfg_max_atoms}) && tag_space;

    // last_gnt=1 means client1 was granted last, so client0 wins the next tie.
    assign gnt0    = !nvdla_core_rst && slot_free && elig0 && (!elig1 || last_gnt);
    assign gnt1    = !nvdla_core_rst && slot_free && elig1 && (!elig0 || !last_gnt);
    assign gnt_any = gnt0 || gnt1;
    assign gnt_pd    = gnt1 ? clt1_req_pd : clt0_req_pd;
    assign gnt_atoms = gnt1 ? need1 : need0;

    assign clt0_req_ready = gnt0;
    assign clt1_req_ready = gnt1;

    assign fifo_ne    = tag_cnt != '0;
    assign head_clt   = tag_mem[rd_ptr][16];
    assign head_atoms = tag_mem[rd_ptr][15:0];

    assign mc_rsp_ready   = !nvdla_core_rst && fifo_ne && (head_clt ? clt1_rsp_ready : clt0_rsp_ready);
    assign clt0_rsp_valid = !nvdla_core_rst && mc_rsp_valid && fifo_ne && !head_clt;
    assign clt1_rsp_valid = !nvdla_core_rst && mc_rsp_valid && fifo_ne && head_clt;
    assign clt0_rsp_pd    = mc_rsp_pd;
    assign clt1_rsp_pd    = mc_rsp_pd;

    assign beat      = mc_rsp_valid && mc_rsp_ready;
    assign head_done = (beat_cnt + 16'd1) == head_atoms;
    assign pop       = beat && head_done;

    always_comb begin
        outs_nxt = outs_cnt;
        if (gnt_any) outs_nxt = outs_nxt + gnt_atoms;
        if (beat)    outs_nxt = outs_nxt - 16'd1;
    end

    always_comb begin
        tag_cnt_nxt = tag_cnt;
        if (gnt_any && !pop)      tag_cnt_nxt = tag_cnt + TAG_ONE;
        else if (!gnt_any && pop) tag_cnt_nxt = tag_cnt - TAG_ONE;
    end

    always_ff @(posedge nvdla_core_clk) begin
        if (nvdla_core_rst) begin
            mc_req_valid <= 1'b0;
            mc_req_pd    <= '0;
            outs_cnt     <= '0;
            wr_ptr       <= '0;
            rd_ptr       <= '0;
            tag_cnt      <= '0;
            beat_cnt     <= '0;
            last_gnt     <= 1'b1;
        end else begin
            if (slot_free) begin
                mc_req_valid <= gnt_any;
                if (gnt_any) mc_req_pd <= gnt_pd;
            end
            if (gnt_any) begin
                last_gnt <= gnt1;
                wr_ptr   <= wr_ptr + 1'b1;
            end
            if (beat) begin
                if (head_done) begin
                    beat_cnt <= '0;
                    rd_ptr   <= rd_ptr + 1'b1;
                end else begin
                    beat_cnt <= beat_cnt + 16'd1;
                end
            end
            outs_cnt <= outs_nxt;
            tag_cnt  <= tag_cnt_nxt;
        end
    end

    // Tag storage needs no reset: entries are only read while the count says they are valid.
    always_ff @(posedge nvdla_core_clk) begin
        if (gnt_any) tag_mem[wr_ptr] <= {gnt1, gnt_atoms};
    end

    assign arb_idle = !mc_req_valid && !fifo_ne && (outs_cnt == 16'd0);

`ifdef NVDLA_CDMA_RD_ARB_STALL_CNT_EN
    logic [31:0] stall_q;
    logic        stall_evt;

    assign stall_evt = slot_free && (clt0_req_valid || clt1_req_valid) && !elig0 && !elig1;

    always_ff @(posedge nvdla_core_clk) begin
        if (nvdla_core_rst) begin
            stall_q <= '0;
        end else if (stall_evt && (stall_q != 32'hFFFF_FFFF)) begin
            stall_q <= stall_q + 32'd1;
        end
    end

    assign stall_cnt = stall_q;
`else
    assign stall_cnt = 32'h0;
`endif

endmodule

// File: tb/tb_nv_nvdla_cdma_rd_arb.sv
// Directed bench for nv_nvdla_cdma_rd_arb: request/response scoreboards plus credit, tag and reset scenarios.
module tb_nv_nvdla_cdma_rd_arb;

    logic         nvdla_core_clk = 1'b0;
    logic         nvdla_core_rst;
    logic         clt0_req_valid, clt1_req_valid;
    logic [78:0]  clt0_req_pd, clt1_req_pd;
    logic         clt0_req_ready, clt1_req_ready;
    logic         mc_req_valid;
    logic [78:0]  mc_req_pd;
    logic         mc_req_ready;
    logic         mc_rsp_valid;
    logic [513:0] mc_rsp_pd;
    logic         mc_rsp_ready;
    logic         clt0_rsp_valid, clt1_rsp_valid;
    logic [513:0] clt0_rsp_pd, clt1_rsp_pd;
    logic         clt0_rsp_ready, clt1_rsp_ready;
    logic [15:0]  cfg_max_atoms;
    logic         arb_idle;
    logic [31:0]  stall_cnt;

    nv_nvdla_cdma_rd_arb #(.TAG_DEPTH(8)) dut (
        .nvdla_core_clk (nvdla_core_clk),
        .nvdla_core_rst (nvdla_core_rst),
        .clt0_req_valid (clt0_req_valid),
        .clt0_req_pd    (clt0_req_pd),
        .clt0_req_ready (clt0_req_ready),
        .clt1_req_valid (clt1_req_valid),
        .clt1_req_pd    (clt1_req_pd),
        .clt1_req_ready (clt1_req_ready),
        .mc_req_valid   (mc_req_valid),
        .mc_req_pd      (mc_req_pd),
        .mc_req_ready   (mc_req_ready),
        .mc_rsp_valid   (mc_rsp_valid),
        .mc_rsp_pd      (mc_rsp_pd),
        .mc_rsp_ready   (mc_rsp_ready),
        .clt0_rsp_valid (clt0_rsp_valid),
        .clt0_rsp_pd    (clt0_rsp_pd),
        .clt0_rsp_ready (clt0_rsp_ready),
        .clt1_rsp_valid (clt1_rsp_valid),
        .clt1_rsp_pd    (clt1_rsp_pd),
        .clt1_rsp_ready (clt1_rsp_ready),
        .cfg_max_atoms  (cfg_max_atoms),
        .arb_idle       (arb_idle),
        .stall_cnt      (stall_cnt)
    );

    always #5 nvdla_core_clk = ~nvdla_core_clk;

    int n_checks = 0;
    int n_pass   = 0;
    logic [78:0]  exp_q[$];
    logic [513:0] exp_rsp0_q[$];
    logic [513:0] exp_rsp1_q[$];

    task automatic check_eq(input string tag, input logic [513:0] got, input logic [513:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    endtask

    task automatic step();
        @(posedge nvdla_core_clk);
        #1;
    endtask

    task automatic sample();
        @(negedge nvdla_core_clk);
    endtask

    function automatic logic [78:0] mk_req(input logic [14:0] size, input logic [63:0] addr);
        return {size, addr};
    endfunction

    function automatic logic [513:0] rand_rsp();
        logic [513:0] v;
        v = '0;
        for (int i = 0; i < 16; i++) v[i*32 +: 32] = $urandom();
        v[513:512] = 2'($urandom_range(0, 3));
        return v;
    endfunction

    function automatic logic [63:0] rand_addr();
        return {$urandom(), $urandom()};
    endfunction

    // Scoreboard monitors: pop and compare whenever the DUT completes a transfer.
    always @(negedge nvdla_core_clk) begin
        if (!nvdla_core_rst && mc_req_valid && mc_req_ready) begin
            if (exp_q.size() == 0) check_eq("mc_req_unexpected", 1, 0);
            else check_eq("mc_req_pd", mc_req_pd, exp_q.pop_front());
        end
        if (!nvdla_core_rst && clt0_rsp_valid && clt0_rsp_ready) begin
            if (exp_rsp0_q.size() == 0) check_eq("clt0_rsp_unexpected", 1, 0);
            else check_eq("clt0_rsp_pd", clt0_rsp_pd, exp_rsp0_q.pop_front());
        end
        if (!nvdla_core_rst && clt1_rsp_valid && clt1_rsp_ready) begin
            if (exp_rsp1_q.size() == 0) check_eq("clt1_rsp_unexpected", 1, 0);
            else check_eq("clt1_rsp_pd", clt1_rsp_pd, exp_rsp1_q.pop_front());
        end
    end

    task automatic send_beat(input bit dst, output int cycles);
        logic [513:0] d;
        int waited;
        d = rand_rsp();
        waited = 0;
        mc_rsp_valid = 1'b1;
        mc_rsp_pd    = d;
        if (dst) exp_rsp1_q.push_back(d);
        else exp_rsp0_q.push_back(d);
        sample();
        while (!mc_rsp_ready && waited < 20) begin
            step();
            sample();
            waited++;
        end
        if (!mc_rsp_ready) check_eq("beat_timeout", 0, 1);
        step();
        mc_rsp_valid = 1'b0;
        cycles = waited + 1;
    endtask

    task automatic drain(input bit dst, input int n);
        int c;
        for (int i = 0; i < n; i++) send_beat(dst, c);
    endtask

    task automatic do_reset();
        nvdla_core_rst = 1'b1;
        clt0_req_valid = 1'b0;
        clt1_req_valid = 1'b0;
        mc_rsp_valid   = 1'b0;
        mc_req_ready   = 1'b1;
        clt0_rsp_ready = 1'b1;
        clt1_rsp_ready = 1'b1;
        exp_q.delete();
        exp_rsp0_q.delete();
        exp_rsp1_q.delete();
        step();
        nvdla_core_rst = 1'b0;
    endtask

    function automatic logic [31:0] exp_stall_val(input int n);
`ifdef NVDLA_CDMA_RD_ARB_STALL_CNT_EN
        return 32'(n);
`else
        return (n < 0) ? 32'd1 : 32'd0;
`endif
    endfunction

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [63:0]  a0, a1;
        logic [78:0]  p, q, r;
        logic [513:0] d;
        bit           exp0;
        int           c, exp_stall;

        nvdla_core_rst = 1'b1;
        clt0_req_valid = 1'b1;
        clt1_req_valid = 1'b0;
        clt0_req_pd    = mk_req(15'd0, 64'h40);
        clt1_req_pd    = '0;
        mc_req_ready   = 1'b1;
        mc_rsp_valid   = 1'b0;
        mc_rsp_pd      = '0;
        clt0_rsp_ready = 1'b1;
        clt1_rsp_ready = 1'b1;
        cfg_max_atoms  = 16'd64;

        // Reset state, including readies held low while reset is asserted.
        step();
        sample();
        check_eq("rst_req_ready0", clt0_req_ready, 0);
        check_eq("rst_mc_req_valid", mc_req_valid, 0);
        check_eq("rst_mc_req_pd", mc_req_pd, 0);
        check_eq("rst_stall_cnt", stall_cnt, 0);
        step();
        clt0_req_valid = 1'b0;
        nvdla_core_rst = 1'b0;
        sample();
        check_eq("post_rst_idle", arb_idle, 1);
        check_eq("post_rst_rsp_ready", mc_rsp_ready, 0);
        step();

        // Round-robin with both clients valid, then exact credit boundary at 16 atoms.
        cfg_max_atoms  = 16'd64;
        a0 = 64'h1000;
        a1 = 64'h2000;
        clt0_req_valid = 1'b1;
        clt1_req_valid = 1'b1;
        for (int k = 0; k < 4; k++) begin
            clt0_req_pd = mk_req(15'd3, a0);
            clt1_req_pd = mk_req(15'd3, a1);
            exp0 = (k % 2 == 0);
            sample();
            check_eq("rr_ready0", clt0_req_ready, exp0);
            check_eq("rr_ready1", clt1_req_ready, !exp0);
            if (exp0) begin
                exp_q.push_back(clt0_req_pd);
                a0 = a0 + 64'h40;
            end else begin
                exp_q.push_back(clt1_req_pd);
                a1 = a1 + 64'h40;
            end
            step();
        end
        clt1_req_valid = 1'b0;
        clt0_req_pd    = mk_req(15'd0, 64'h3000);
        cfg_max_atoms  = 16'd16;
        sample();
        check_eq("credit16_block", clt0_req_ready, 0);
        step();
        cfg_max_atoms = 16'd17;
        sample();
        check_eq("credit17_grant", clt0_req_ready, 1);
        exp_q.push_back(clt0_req_pd);
        step();
        clt0_req_valid = 1'b0;
        sample();
        check_eq("req_valid_after_grant", mc_req_valid, 1);
        check_eq("busy_not_idle", arb_idle, 0);
        step();
        sample();
        check_eq("req_valid_drop", mc_req_valid, 0);
        step();
        drain(0, 4);
        drain(1, 4);
        drain(0, 4);
        drain(1, 4);
        drain(0, 1);
        sample();
        check_eq("rr_idle", arb_idle, 1);
        step();

        // Credit stall: clt1 waits for one returned beat.
        do_reset();
        cfg_max_atoms  = 16'd8;
        exp_stall      = 0;
        clt0_req_valid = 1'b1;
        clt0_req_pd    = mk_req(15'd7, rand_addr());
        sample();
        check_eq("stall_clt0_grant", clt0_req_ready, 1);
        exp_q.push_back(clt0_req_pd);
        step();
        clt0_req_valid = 1'b0;
        clt1_req_valid = 1'b1;
        clt1_req_pd    = mk_req(15'd0, rand_addr());
        for (int k = 0; k < 3; k++) begin
            sample();
            check_eq("stall_clt1_blocked", clt1_req_ready, 0);
            exp_stall++;
            step();
        end
        send_beat(0, c);
        exp_stall += c;
        sample();
        check_eq("stall_clt1_grant", clt1_req_ready, 1);
        exp_q.push_back(clt1_req_pd);
        step();
        clt1_req_valid = 1'b0;
        sample();
        check_eq("stall_cnt", stall_cnt, exp_stall_val(exp_stall));
        step();
        drain(0, 7);
        drain(1, 1);
        sample();
        check_eq("stall_idle", arb_idle, 1);
        step();

        // Tag FIFO full after 8 single-atom grants; one beat frees one slot.
        do_reset();
        cfg_max_atoms  = 16'd1000;
        clt0_req_valid = 1'b1;
        for (int k = 0; k < 8; k++) begin
            clt0_req_pd = mk_req(15'd0, rand_addr());
            sample();
            check_eq("tag_fill_grant", clt0_req_ready, 1);
            exp_q.push_back(clt0_req_pd);
            step();
        end
        clt0_req_pd = mk_req(15'd0, rand_addr());
        for (int k = 0; k < 2; k++) begin
            sample();
            check_eq("tag_full_block", clt0_req_ready, 0);
            step();
        end
        send_beat(0, c);
        sample();
        check_eq("tag_freed_grant", clt0_req_ready, 1);
        exp_q.push_back(clt0_req_pd);
        step();
        clt0_req_pd = mk_req(15'd0, rand_addr());
        sample();
        check_eq("tag_full_again", clt0_req_ready, 0);
        step();
        clt0_req_valid = 1'b0;
        drain(0, 8);
        sample();
        check_eq("tag_idle", arb_idle, 1);
        step();

        // MC back-pressure holds the request stable and blocks further grants.
        do_reset();
        cfg_max_atoms  = 16'd64;
        p = mk_req(15'd1, rand_addr());
        q = mk_req(15'd1, rand_addr());
        r = mk_req(15'd1, rand_addr());
        clt0_req_valid = 1'b1;
        clt0_req_pd    = p;
        sample();
        check_eq("bp_first_grant", clt0_req_ready, 1);
        exp_q.push_back(p);
        step();
        mc_req_ready   = 1'b0;
        clt0_req_pd    = q;
        clt1_req_valid = 1'b1;
        clt1_req_pd    = r;
        for (int k = 0; k < 5; k++) begin
            sample();
            check_eq("bp_valid_held", mc_req_valid, 1);
            check_eq("bp_pd_held", mc_req_pd, p);
            check_eq("bp_no_grant0", clt0_req_ready, 0);
            check_eq("bp_no_grant1", clt1_req_ready, 0);
            step();
        end
        mc_req_ready = 1'b1;
        sample();
        check_eq("bp_release_grant1", clt1_req_ready, 1);
        check_eq("bp_release_grant0", clt0_req_ready, 0);
        exp_q.push_back(r);
        step();
        clt1_req_valid = 1'b0;
        sample();
        check_eq("bp_next_grant0", clt0_req_ready, 1);
        exp_q.push_back(q);
        step();
        clt0_req_valid = 1'b0;
        drain(0, 2);
        drain(1, 2);
        drain(0, 2);
        sample();
        check_eq("bp_idle", arb_idle, 1);
        step();

        // Zero credit, empty-FIFO refusal, and response back-pressure routing.
        do_reset();
        cfg_max_atoms  = 16'd0;
        clt1_req_valid = 1'b1;
        clt1_req_pd    = mk_req(15'd1, rand_addr());
        mc_rsp_valid   = 1'b1;
        mc_rsp_pd      = rand_rsp();
        sample();
        check_eq("cfg0_block", clt1_req_ready, 0);
        check_eq("empty_rsp_refused", mc_rsp_ready, 0);
        check_eq("empty_rsp_v0", clt0_rsp_valid, 0);
        check_eq("empty_rsp_v1", clt1_rsp_valid, 0);
        step();
        mc_rsp_valid = 1'b0;
        sample();
        check_eq("cfg0_block2", clt1_req_ready, 0);
        step();
        cfg_max_atoms = 16'd64;
        sample();
        check_eq("route_grant1", clt1_req_ready, 1);
        exp_q.push_back(clt1_req_pd);
        step();
        clt1_req_valid = 1'b0;
        clt0_req_valid = 1'b1;
        clt0_req_pd    = mk_req(15'd0, rand_addr());
        sample();
        check_eq("route_grant0", clt0_req_ready, 1);
        exp_q.push_back(clt0_req_pd);
        step();
        clt0_req_valid = 1'b0;
        send_beat(1, c);
        d = rand_rsp();
        mc_rsp_valid   = 1'b1;
        mc_rsp_pd      = d;
        clt1_rsp_ready = 1'b0;
        exp_rsp1_q.push_back(d);
        sample();
        check_eq("rsp_bp_ready", mc_rsp_ready, 0);
        check_eq("rsp_bp_valid1", clt1_rsp_valid, 1);
        step();
        clt1_rsp_ready = 1'b1;
        sample();
        check_eq("rsp_bp_release", mc_rsp_ready, 1);
        step();
        d = rand_rsp();
        mc_rsp_pd = d;
        exp_rsp0_q.push_back(d);
        sample();
        check_eq("rsp_beat3_v0", clt0_rsp_valid, 1);
        check_eq("rsp_beat3_v1", clt1_rsp_valid, 0);
        step();
        mc_rsp_valid = 1'b0;
        sample();
        check_eq("route_idle", arb_idle, 1);
        step();

        // Reset with three tags outstanding discards them and the credits.
        do_reset();
        cfg_max_atoms  = 16'd64;
        clt0_req_valid = 1'b1;
        for (int k = 0; k < 3; k++) begin
            clt0_req_pd = mk_req(15'd0, rand_addr());
            sample();
            check_eq("mid_rst_grant", clt0_req_ready, 1);
            exp_q.push_back(clt0_req_pd);
            step();
        end
        clt0_req_valid = 1'b0;
        step();
        nvdla_core_rst = 1'b1;
        mc_rsp_valid   = 1'b1;
        mc_rsp_pd      = rand_rsp();
        sample();
        check_eq("in_rst_rsp_ready", mc_rsp_ready, 0);
        check_eq("in_rst_rsp_valid0", clt0_rsp_valid, 0);
        step();
        nvdla_core_rst = 1'b0;
        sample();
        check_eq("mid_rst_idle", arb_idle, 1);
        check_eq("mid_rst_rsp_ready", mc_rsp_ready, 0);
        check_eq("mid_rst_req_valid", mc_req_valid, 0);
        check_eq("mid_rst_stall", stall_cnt, 0);
        step();
        mc_rsp_valid   = 1'b0;
        cfg_max_atoms  = 16'd1;
        clt0_req_valid = 1'b1;
        clt0_req_pd    = mk_req(15'd0, rand_addr());
        sample();
        check_eq("mid_rst_credit_free", clt0_req_ready, 1);
        exp_q.push_back(clt0_req_pd);
        step();
        clt0_req_valid = 1'b0;
        send_beat(0, c);
        sample();
        check_eq("final_idle", arb_idle, 1);
        step();

        check_eq("req_q_left", 514'(exp_q.size()), 0);
        check_eq("rsp0_q_left", 514'(exp_rsp0_q.size()), 0);
        check_eq("rsp1_q_left", 514'(exp_rsp1_q.size()), 0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
